// File: rtl/linebuf_window3x3_if.sv
// Window-source bundle: pixel stream in, registered 3x3 window out.
// master = producer/consumer side, slave = linebuf_window3x3.
interface linebuf_window3x3_if #(
  parameter int WIDTH = 32
);
  logic                        in_valid;
  logic [WIDTH-1:0]            in_data;
  logic [2:0][2:0]             win_rd_en;
  logic [2:0][2:0][WIDTH-1:0]  win_rd_data;
  logic                        win_valid;
  logic                        frame_done;
  logic                        rd_err;

  modport master (
    output in_valid, in_data, win_rd_en,
    input  win_rd_data, win_valid, frame_done, rd_err
  );

  modport slave (
    input  in_valid, in_data, win_rd_en,
    output win_rd_data, win_valid, frame_done, rd_err
  );
endinterface

// File: rtl/linebuf_window3x3.sv
// Streaming 3x3 window source with two row line buffers.
// Ports: clk, rst (async high), bus (slave: pixel in / window out).
// Optional LINEBUF_RD_CHECK_EN: sticky rd_err on reads of an
// invalid window; otherwise rd_err = 0.
module linebuf_window3x3 #(
  parameter int WIDTH = 32,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input logic                clk,
  input logic                rst,
  linebuf_window3x3_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]              col;
  logic [RW-1:0]              row;
  logic [WIDTH-1:0]           lb0 [IMG_W];
  logic [WIDTH-1:0]           lb1 [IMG_W];
  logic [2:0][2:0][WIDTH-1:0] win;
  logic                       win_valid;
  logic                       frame_done;
  logic                       col_last;
  logic                       row_last;

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));

  // Line buffers carry no reset; stale data is masked by win_valid.
  // A pixel arriving while rst is high is dropped.
  always_ff @(posedge clk) begin
    if (bus.in_valid && !rst) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      win        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (bus.in_valid) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2]  <= lb1[col];
      win[1][2]  <= lb0[col];
      win[2][2]  <= bus.in_data;
      win_valid  <= (row >= RW'(2)) && (col >= CW'(2));
      frame_done <= col_last && row_last;
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

  assign bus.win_rd_data = win;
  assign bus.win_valid   = win_valid;
  assign bus.frame_done  = frame_done;

`ifdef LINEBUF_RD_CHECK_EN
  logic rd_hit;
  logic rd_err;

  assign rd_hit = (|bus.win_rd_en) && !win_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_err <= 1'b0;
    end else if (rd_hit) begin
      rd_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!rd_hit)
        else $error("window read while win_valid is low");
    end
  end

  assign bus.rd_err = rd_err;
`else
  logic unused_rd_en;

  assign unused_rd_en = ^bus.win_rd_en;
  assign bus.rd_err   = 1'b0;
`endif
endmodule

// File: tb/tb_linebuf_window3x3.sv
// Directed bench for linebuf_window3x3 on a 4x4 image.
// pixel(r,c) = 10r+c; window taps checked against that formula.
module tb_linebuf_window3x3;
  localparam int W  = 32;
  localparam int IW = 4;
  localparam int IH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_err = 1'b0;

  linebuf_window3x3_if #(.WIDTH(W)) bus ();

  linebuf_window3x3 #(
    .WIDTH(W),
    .IMG_W(IW),
    .IMG_H(IH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input int r, input int c);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("tap[%0d][%0d]@(%0d,%0d)", i, j, r, c),
            bus.win_rd_data[i][j],
            32'(10 * (r - 2 + i) + (c - 2 + j)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.win_valid), 32'd0);
    chk({tag, "_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_err"}, 32'(bus.rd_err), 32'd0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("%s_tap[%0d][%0d]", tag, i, j),
            bus.win_rd_data[i][j], 32'd0);
  endtask

  task automatic push(input int r, input int c, input logic rd);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'(10 * r + c);
    bus.win_rd_en = rd ? 9'b000_010_000 : 9'b0;
`ifdef LINEBUF_RD_CHECK_EN
    if (rd && !bus.win_valid) exp_err = 1'b1;
`endif
    @(posedge clk);
    #1;
    bus.win_rd_en = '0;
    chk($sformatf("valid@(%0d,%0d)", r, c), 32'(bus.win_valid),
        32'((r >= 2) && (c >= 2)));
    chk($sformatf("done@(%0d,%0d)", r, c), 32'(bus.frame_done),
        32'((r == IH - 1) && (c == IW - 1)));
    chk($sformatf("err@(%0d,%0d)", r, c), 32'(bus.rd_err),
        32'(exp_err));
    if ((r >= 2) && (c >= 2)) chk_win(r, c);
  endtask

  task automatic push_frame();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        push(r, c, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.win_rd_en = '0;

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // frame 1 up to pixel 22
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < IW; c++)
        push(r, c, 1'b0);
    for (int c = 0; c < 3; c++) push(2, c, 1'b0);

    // stall: window must stay frozen at the 22-window
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hdead_beef;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_valid%0d", k), 32'(bus.win_valid), 32'd1);
      chk($sformatf("hold_done%0d", k), 32'(bus.frame_done), 32'd0);
      chk_win(2, 2);
    end

    // rest of frame 1; frame_done checked at (3,3)
    push(2, 3, 1'b0);
    for (int c = 0; c < IW; c++) push(3, c, 1'b0);

    // frame 2: rows 0,1 invalid despite stale buffers; read at (0,1)
    push(0, 0, 1'b0);
    push(0, 1, 1'b1);
    push(0, 2, 1'b0);
    push(0, 3, 1'b0);
    for (int c = 0; c < IW; c++) push(1, c, 1'b0);
    for (int c = 0; c < IW; c++) push(2, c, 1'b0);

    // async reset mid-frame, with a pixel that must be dropped
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    bus.in_data = 32'd99;
    @(posedge clk);
    #1;
    chk_zero("rst_drop");
    bus.in_valid = 1'b0;
    rst = 1'b0;
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("post_rst");

    // full clean frame after reset, then idle
    push_frame();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("done_clears", 32'(bus.frame_done), 32'd0);
    chk("idle_valid", 32'(bus.win_valid), 32'd1);
    chk_win(3, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
